// File: rtl/pdp1_opr_unit.sv
// pdp1_opr_unit
// Sequencer in front of the combinational operate-group (OPR) decoder.
// Accepts one OPR word per handshake, latches the operands (AC, IO, program
// flags, synchronised test word) for the decoder, captures the decoder
// results, and issues one writeback strobe per instruction. Each instruction
// is stretched to OPR_CYCLES cycles. HLT (mask bit 3) parks the unit until a
// console continue pulse arrives.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   opr_valid/opr_ready   instruction handshake (ready only while idle)
//   opr_word[0:17]        bits 0:4 opcode, bit 5 i-bit, bits 6:17 mask
//   ac_i, io_i, pf_i      current AC / IO / program flags
//   tw_async              console test-word switches (asynchronous)
//   dec_*                 latched operands presented to the decoder
//   dec_r_*               decoder results
//   wb_we, wb_ac/io/pf    writeback strobe and registered results
//   halted, cont          HLT status and console continue pulse
//   opr_err               one-cycle pulse when a non-OPR opcode was accepted
module pdp1_opr_unit #(
    parameter int OPR_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        opr_valid,
    output logic        opr_ready,
    input  logic [0:17] opr_word,
    input  logic [0:17] ac_i,
    input  logic [0:17] io_i,
    input  logic [0:5]  pf_i,
    input  logic [0:17] tw_async,
    output logic        dec_i,
    output logic [0:11] dec_mask,
    output logic [0:17] dec_ac,
    output logic [0:17] dec_io,
    output logic [0:17] dec_tw,
    output logic [0:5]  dec_pf,
    input  logic [0:17] dec_r_ac,
    input  logic [0:17] dec_r_io,
    input  logic [0:5]  dec_r_pf,
    output logic        wb_we,
    output logic [0:17] wb_ac,
    output logic [0:17] wb_io,
    output logic [0:5]  wb_pf,
    output logic        halted,
    input  logic        cont,
    output logic        opr_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EVAL,
        S_STALL,
        S_WB,
        S_HALT
    } state_t;

    localparam logic [3:0] LAST_STALL = 4'(OPR_CYCLES - 1);

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic [0:17] r_tw_s1;
    logic [0:17] r_tw_s2;
    logic [0:4]  r_opc;
    logic        r_ready;
    logic        r_wb_we;
    logic        r_halted;
    logic        r_err;
    logic        r_dec_i;
    logic [0:11] r_dec_mask;
    logic [0:17] r_dec_ac;
    logic [0:17] r_dec_io;
    logic [0:17] r_dec_tw;
    logic [0:5]  r_dec_pf;
    logic [0:17] r_wb_ac;
    logic [0:17] r_wb_io;
    logic [0:5]  r_wb_pf;
    logic        w_accept;
    logic        w_is_opr;

    // r_ready is only ever set when the next state is IDLE, so it also gates
    // acceptance during the first cycle after reset release.
    assign w_accept = opr_valid && r_ready;
    assign w_is_opr = (r_opc == 5'b11111);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_EVAL;
            S_EVAL: begin
                if (!w_is_opr)            w_next = S_IDLE;
                else if (OPR_CYCLES <= 2) w_next = S_WB;
                else                      w_next = S_STALL;
            end
            S_STALL: if (r_cnt == LAST_STALL) w_next = S_WB;
            S_WB:    w_next = r_dec_mask[3] ? S_HALT : S_IDLE;
            S_HALT:  if (cont) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they are glitch
    // free and all drop together on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_ready  <= 1'b0;
            r_wb_we  <= 1'b0;
            r_halted <= 1'b0;
            r_err    <= 1'b0;
            r_cnt    <= 4'd0;
        end else begin
            r_state  <= w_next;
            r_ready  <= (w_next == S_IDLE);
            r_wb_we  <= (w_next == S_WB);
            r_halted <= (w_next == S_HALT);
            r_err    <= (r_state == S_EVAL) && !w_is_opr;
            if (w_accept)
                r_cnt <= 4'd1;
            else if (r_state == S_EVAL || r_state == S_STALL)
                r_cnt <= r_cnt + 4'd1;
        end
    end

    // Two-flop synchroniser; dec_tw samples the second stage at acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tw_s1 <= '0;
            r_tw_s2 <= '0;
        end else begin
            r_tw_s1 <= tw_async;
            r_tw_s2 <= r_tw_s1;
        end
    end

    // Operand latches hold through writeback and any HALT so the decoder
    // inputs stay stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_opc      <= '0;
            r_dec_i    <= 1'b0;
            r_dec_mask <= '0;
            r_dec_ac   <= '0;
            r_dec_io   <= '0;
            r_dec_tw   <= '0;
            r_dec_pf   <= '0;
        end else if (w_accept) begin
            r_opc      <= opr_word[0:4];
            r_dec_i    <= opr_word[5];
            r_dec_mask <= opr_word[6:17];
            r_dec_ac   <= ac_i;
            r_dec_io   <= io_i;
            r_dec_tw   <= r_tw_s2;
            r_dec_pf   <= pf_i;
        end
    end

    // Results are captured at the end of EVAL, only for genuine OPR words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_ac <= '0;
            r_wb_io <= '0;
            r_wb_pf <= '0;
        end else if (r_state == S_EVAL && w_is_opr) begin
            r_wb_ac <= dec_r_ac;
            r_wb_io <= dec_r_io;
            r_wb_pf <= dec_r_pf;
        end
    end

    assign opr_ready = r_ready;
    assign wb_we     = r_wb_we;
    assign halted    = r_halted;
    assign opr_err   = r_err;
    assign dec_i     = r_dec_i;
    assign dec_mask  = r_dec_mask;
    assign dec_ac    = r_dec_ac;
    assign dec_io    = r_dec_io;
    assign dec_tw    = r_dec_tw;
    assign dec_pf    = r_dec_pf;
    assign wb_ac     = r_wb_ac;
    assign wb_io     = r_wb_io;
    assign wb_pf     = r_wb_pf;

endmodule

// File: doc/pdp1_opr_unit.md
# pdp1_opr_unit

Sequencer that sits directly upstream of the operate-group (OPR) decoder. It:
- accepts OPR instruction words from the main control over a valid/ready handshake;
- latches AC, IO, program flags and a synchronised test word, and presents them to the combinational decoder;
- captures the decoder results and issues one writeback pulse per instruction.

It also stretches each instruction to a programmable cycle count and implements the HLT stop/continue behaviour.

## Interface
- OPR_CYCLES, 3, clock cycles from acceptance edge to the writeback cycle; legal range 2..15.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- opr_valid  in  1  instruction word valid.
- opr_ready  out  1  unit can accept; high only in IDLE.
- opr_word  in  [0:17]  instruction word; bits 0:4 opcode, bit 5 i-bit, bits 6:17 mask.
- ac_i, io_i  in  [0:17]  current AC and IO register contents.
- pf_i  in  [0:5]  current program flags.
- tw_async  in  [0:17]  console test-word switches, asynchronous.
- dec_i  out  1  i-bit to decoder.
- dec_mask  out  [0:11]  mask to decoder.
- dec_ac, dec_io, dec_tw  out  [0:17]  latched operands to decoder.
- dec_pf  out  [0:5]  latched flags to decoder.
- dec_r_ac, dec_r_io  in  [0:17]  decoder results.
- dec_r_pf  in  [0:5]  decoder flag result.
- wb_we  out  1  one-cycle writeback strobe.
- wb_ac, wb_io  out  [0:17]  registered results.
- wb_pf  out  [0:5]  registered flag result.
- halted  out  1  unit is stopped by HLT.
- cont  in  1  console continue; single-cycle pulse.
- opr_err  out  1  one-cycle pulse: a non-OPR opcode was accepted.

## Operation
- Reset: all of the following are 0.
  - Outputs: opr_ready, wb_we, halted, opr_err, wb_ac, wb_io, wb_pf, and every dec_* output.
  - Internal: tw synchroniser and cycle counter.
  - State: IDLE.
  - opr_ready rises in the first cycle after rst_n deasserts.
- Test word: tw_async goes through a two-flop synchroniser every cycle. dec_tw takes the synchronised value at the acceptance edge and holds it for the whole instruction.
- States:
  - IDLE: opr_ready=1. When opr_valid && opr_ready at an edge, latch opr_word, ac_i, io_i, pf_i and the synced tw. Counter := 1. Go to EVAL.
  - EVAL: dec_* outputs are driven from the latches. At the closing edge, capture dec_r_ac/io/pf into wb_ac/io/pf and go to STALL.
    - If opcode != 5'b11111: capture nothing, pulse opr_err for one cycle, return to IDLE.
  - STALL: counter increments each cycle. When the counter reaches OPR_CYCLES-1, go to WB. With OPR_CYCLES=2, STALL lasts 0 cycles and EVAL goes straight to WB.
  - WB: wb_we=1 for exactly this cycle. Next state is HALT if mask[3] (HLT) is set, else IDLE.
  - HALT: halted=1, opr_ready=0. A cont pulse returns to IDLE, and halted clears on the same edge.
- dec_* outputs hold their last latched values in IDLE and HALT, so the decoder inputs are stable through writeback.
- wb_ac/io/pf hold their values until the next EVAL capture.

## Timing
- Acceptance edge = edge 0. EVAL occupies cycle 1. wb_we is high during cycle OPR_CYCLES.
- For a non-halting instruction, opr_ready is high again in cycle OPR_CYCLES+1. Back-to-back throughput is one instruction per OPR_CYCLES+1 cycles.
- A non-OPR opcode: opr_err is high in cycle 2 and opr_ready is high in cycle 2. No wb_we.
- Async edges on tw_async are visible to dec_tw only if they occur at least 2 edges before acceptance.
- cont outside HALT is ignored.
- cont during the WB cycle of a HLT instruction is ignored; the unit still enters HALT.
- opr_valid outside IDLE is ignored; the word is not consumed.
- rst_n low in any state forces IDLE immediately and asynchronously. wb_we drops at once, and any pending writeback is discarded.
- The 12-bit mask is consumed verbatim. The unit does not interpret any mask bit except bit 3.

## Test plan
- OPR_CYCLES=3, ac_i=0o123456, opr_word=0o760200 (CLA), decoder returns 0 -> wb_we high in cycle 3 only, wb_ac=0; opr_ready low in cycles 1-3, high in cycle 4.
- tw_async=0o707070 held, opr_word=0o762200 (CLA+LAT) -> dec_tw=0o707070 in cycle 1; wb_ac equals dec_r_ac=0o707070.
- pf_i=0, opr_word=0o760011 (STF 1) -> dec_mask=0o0011; wb_pf equals decoder value 6'b000001.
- opr_word=0o760400 (HLT) -> halted=1 from cycle 4; opr_valid ignored for 10 cycles; cont pulse -> halted=0 and opr_ready=1 next cycle.
- opr_word=0o200000 (non-OPR) -> opr_err pulse in cycle 2, no wb_we, opr_ready=1 in cycle 2.
- rst_n pulsed low during STALL -> wb_we never asserts, all outputs 0, opr_ready=1 one cycle after release; OPR_CYCLES=2 variant shows wb_we in cycle 2.
